// File: rtl/mc_mem_pkg.sv
// Shared constants, direction encoding and packed-channel indexing helper
// for the multi-channel memory slave.
package mc_mem_pkg;

   localparam int DEF_DEPTH  = 64;
   localparam int DEF_WIDTH  = 4;
   localparam int DEF_NUM_CH = 2;

   typedef enum logic {
      RD = 1'b0,
      WR = 1'b1
   } dir_e;

   // Low bit of channel ch inside a vector packed at w bits per channel.
   function automatic int chan_slice(input int ch, input int w);
      return ch * w;
   endfunction

endpackage

// File: rtl/mc_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from a
// priority pointer that moves past the winner whenever a transfer happens.
module mc_rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;

   always_comb begin
      logic found;
      int   idx;
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int off = 0; off < N; off++) begin
         idx = (int'(ptr_q) + off) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            ptr_d    = PW'((idx + 1) % N);
         end
      end
      if (!advance) ptr_d = ptr_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mc_mem_slave.sv
// Multi-channel single-port memory slave with round-robin arbitration,
// 1- or 2-cycle read latency and out-of-range flagging.
// Optional access counters are enabled by defining MC_MEM_STATS_EN.
module mc_mem_slave
   import mc_mem_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int READ_LAT   = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NUM_CH-1:0]            valid_i,
   input  logic [NUM_CH-1:0]            wr_rd_en_i,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_i,
   input  logic [NUM_CH*WIDTH-1:0]      w_data_i,
   output logic [NUM_CH-1:0]            ready_o,
   output logic [WIDTH-1:0]             rdata_o,
   output logic [NUM_CH-1:0]            rvalid_o,
   output logic                         err_o
`ifdef MC_MEM_STATS_EN
   ,
   output logic [15:0]                  wr_cnt_o,
   output logic [15:0]                  rd_cnt_o
`endif
);

   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   logic [NUM_CH-1:0]     gnt;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [WIDTH-1:0]      sel_wdata;
   dir_e                  sel_dir;
   logic                  in_range;
   logic                  wr_en;
   logic [WIDTH-1:0]      rd_data;
   logic [WIDTH-1:0]      mem_q [DEPTH];

   mc_rr_arbiter #(.N(NUM_CH)) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req     (valid_i),
      .advance (accept),
      .gnt     (gnt)
   );

   // A grant is only ever given to a valid channel, so any ready is a transfer.
   assign ready_o = rst_i ? '0 : gnt;
   assign accept  = |ready_o;

   always_comb begin
      int sel;
      sel = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (gnt[c]) sel = c;
      end
      sel_addr  = addr_i[chan_slice(sel, ADDR_WIDTH) +: ADDR_WIDTH];
      sel_wdata = w_data_i[chan_slice(sel, WIDTH) +: WIDTH];
      sel_dir   = dir_e'(wr_rd_en_i[sel]);
   end

   assign in_range = {1'b0, sel_addr} < DEPTH_W;
   assign wr_en    = accept && (sel_dir == WR) && in_range;
   assign rd_data  = in_range ? mem_q[in_range ? sel_addr : '0] : '0;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk_i) begin
         if (rst_i)                                          mem_q[gi] <= '0;
         else if (wr_en && sel_addr == ADDR_WIDTH'(gi))      mem_q[gi] <= sel_wdata;
      end
   end

   logic [NUM_CH-1:0] s1_vld_q, s1_vld_d;
   logic [WIDTH-1:0]  s1_data_q, s1_data_d;
   logic              err_q, err_d;

   always_comb begin
      s1_vld_d  = (accept && sel_dir == RD) ? ready_o : '0;
      s1_data_d = (|s1_vld_d) ? rd_data : s1_data_q;
      err_d     = accept && !in_range;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_vld_q  <= '0;
         s1_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_data_q <= s1_data_d;
         err_q     <= err_d;
      end
   end

   assign err_o = err_q;

   if (READ_LAT == 2) begin : g_lat2
      logic [NUM_CH-1:0] out_vld_q;
      logic [WIDTH-1:0]  out_data_q, out_data_d;

      always_comb out_data_d = (|s1_vld_q) ? s1_data_q : out_data_q;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            out_vld_q  <= '0;
            out_data_q <= '0;
         end else begin
            out_vld_q  <= s1_vld_q;
            out_data_q <= out_data_d;
         end
      end

      assign rvalid_o = out_vld_q;
      assign rdata_o  = out_data_q;
   end else begin : g_lat1
      assign rvalid_o = s1_vld_q;
      assign rdata_o  = s1_data_q;
   end

`ifdef MC_MEM_STATS_EN
   logic [15:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

   // Out-of-range accesses are still counted; counters stick at all-ones.
   always_comb begin
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      if (accept && sel_dir == WR && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      if (accept && sel_dir == RD && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   assign wr_cnt_o = wr_cnt_q;
   assign rd_cnt_o = rd_cnt_q;
`endif

endmodule

// File: tb/tb_mc_mem_slave.sv
// Bench for mc_mem_slave: one instance per read latency sharing stimulus,
// a directed vector table, then constrained-random traffic against a model.
module tb_mc_mem_slave;

   localparam int NCH = 2;
   localparam int DEP = 50;
   localparam int W   = 4;
   localparam int AW  = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic [NCH-1:0]     valid, wr;
   logic [NCH*AW-1:0]  addr;
   logic [NCH*W-1:0]   wdata;
   logic [NCH-1:0]     ready1, ready2, rvalid1, rvalid2;
   logic [W-1:0]       rdata1, rdata2;
   logic               err1, err2;
`ifdef MC_MEM_STATS_EN
   logic [15:0]        wc1, rc1, wc2, rc2;
`endif

   mc_mem_slave #(.NUM_CH(NCH), .DEPTH(DEP), .WIDTH(W), .ADDR_WIDTH(AW), .READ_LAT(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .wr_rd_en_i(wr), .addr_i(addr),
      .w_data_i(wdata), .ready_o(ready1), .rdata_o(rdata1), .rvalid_o(rvalid1), .err_o(err1)
`ifdef MC_MEM_STATS_EN
      , .wr_cnt_o(wc1), .rd_cnt_o(rc1)
`endif
   );

   mc_mem_slave #(.NUM_CH(NCH), .DEPTH(DEP), .WIDTH(W), .ADDR_WIDTH(AW), .READ_LAT(2)) u_dut2 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .wr_rd_en_i(wr), .addr_i(addr),
      .w_data_i(wdata), .ready_o(ready2), .rdata_o(rdata2), .rvalid_o(rvalid2), .err_o(err2)
`ifdef MC_MEM_STATS_EN
      , .wr_cnt_o(wc2), .rd_cnt_o(rc2)
`endif
   );

   // Reference model state
   logic [W-1:0]   mem_m [DEP];
   int             ptr_m = 0;
   logic [NCH-1:0] cur_vld = '0, prev_vld = '0, rdy_seen = '0;
   logic [W-1:0]   cur_data = '0, prev_data = '0, last1 = '0, last2 = '0;
   logic           err_m = 1'b0;
   int             wcnt = 0, rcnt = 0;
   int             total = 0, bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   function automatic int pick(input logic [NCH-1:0] v, input int p);
      for (int k = 0; k < NCH; k++) begin
         if (v[(p + k) % NCH]) return (p + k) % NCH;
      end
      return -1;
   endfunction

   // One clock: check grant before the edge, advance model, check outputs after.
   task automatic step();
      logic [NCH-1:0] exp_rdy;
      int g, a;
      @(negedge clk);
      g = rst ? -1 : pick(valid, ptr_m);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      rdy_seen = ready1;
      chk("ready1", 32'(ready1), 32'(exp_rdy));
      chk("ready2", 32'(ready2), 32'(exp_rdy));
      @(posedge clk);
      prev_vld  = cur_vld;
      prev_data = cur_data;
      cur_vld   = '0;
      err_m     = 1'b0;
      if (rst) begin
         for (int i = 0; i < DEP; i++) mem_m[i] = '0;
         ptr_m = 0; prev_vld = '0; last1 = '0; last2 = '0;
         wcnt = 0; rcnt = 0;
      end else if (g >= 0) begin
         a = int'(addr[g*AW +: AW]);
         ptr_m = (g + 1) % NCH;
         err_m = (a >= DEP);
         if (wr[g]) begin
            if (a < DEP) mem_m[a] = wdata[g*W +: W];
            wcnt = (wcnt < 65535) ? wcnt + 1 : 65535;
         end else begin
            cur_vld  = exp_rdy;
            cur_data = (a < DEP) ? mem_m[a] : '0;
            rcnt = (rcnt < 65535) ? rcnt + 1 : 65535;
         end
      end
      if (cur_vld != '0)  last1 = cur_data;
      if (prev_vld != '0) last2 = prev_data;
      #1;
      chk("rvalid1", 32'(rvalid1), 32'(cur_vld));
      chk("rdata1",  32'(rdata1),  32'(last1));
      chk("err1",    32'(err1),    32'(err_m));
      chk("rvalid2", 32'(rvalid2), 32'(prev_vld));
      chk("rdata2",  32'(rdata2),  32'(last2));
      chk("err2",    32'(err2),    32'(err_m));
`ifdef MC_MEM_STATS_EN
      chk("wr_cnt1", 32'(wc1), 32'(wcnt));
      chk("rd_cnt1", 32'(rc1), 32'(rcnt));
      chk("wr_cnt2", 32'(wc2), 32'(wcnt));
      chk("rd_cnt2", 32'(rc2), 32'(rcnt));
`endif
   endtask

   typedef struct {
      logic           rst;
      logic [1:0]     v, wr;
      logic [AW-1:0]  a0, a1;
      logic [W-1:0]   d0, d1;
      logic [1:0]     e_rdy, e_rvld;
      logic [W-1:0]   e_rdata;
      logic           e_err;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [1:0] w,
                               input int a0, input int a1, input int d0, input int d1,
                               input logic [1:0] erdy, input logic [1:0] ervld,
                               input int erd, input logic eerr);
      vec_t x;
      x.rst = r; x.v = v; x.wr = w;
      x.a0 = AW'(a0); x.a1 = AW'(a1); x.d0 = W'(d0); x.d1 = W'(d1);
      x.e_rdy = erdy; x.e_rvld = ervld; x.e_rdata = W'(erd); x.e_err = eerr;
      return x;
   endfunction

   vec_t tbl [19];

   initial begin
      rst = 1'b1; valid = '0; wr = '0; addr = '0; wdata = '0;

      tbl[0]  = mk(1, 2'b00, 2'b00,  0,  0,  0, 0, 2'b00, 2'b00, 0,  0);
      tbl[1]  = mk(0, 2'b01, 2'b00,  5,  0,  0, 0, 2'b01, 2'b01, 0,  0);
      tbl[2]  = mk(0, 2'b01, 2'b01, 10,  0, 10, 0, 2'b01, 2'b00, 0,  0);
      tbl[3]  = mk(0, 2'b01, 2'b00, 10,  0,  0, 0, 2'b01, 2'b01, 10, 0);
      tbl[4]  = mk(0, 2'b01, 2'b01,  1,  0,  3, 0, 2'b01, 2'b00, 10, 0);
      tbl[5]  = mk(0, 2'b10, 2'b10,  0,  2,  0, 7, 2'b10, 2'b00, 10, 0);
      tbl[6]  = mk(0, 2'b11, 2'b00,  1,  2,  0, 0, 2'b01, 2'b01, 3,  0);
      tbl[7]  = mk(0, 2'b11, 2'b00,  1,  2,  0, 0, 2'b10, 2'b10, 7,  0);
      tbl[8]  = mk(0, 2'b11, 2'b00,  1,  2,  0, 0, 2'b01, 2'b01, 3,  0);
      tbl[9]  = mk(0, 2'b11, 2'b00,  1,  2,  0, 0, 2'b10, 2'b10, 7,  0);
      tbl[10] = mk(0, 2'b01, 2'b01, 55,  0, 15, 0, 2'b01, 2'b00, 7,  1);
      tbl[11] = mk(0, 2'b10, 2'b10,  0, 49,  0, 9, 2'b10, 2'b00, 7,  0);
      tbl[12] = mk(0, 2'b10, 2'b00,  0, 55,  0, 0, 2'b10, 2'b10, 0,  1);
      tbl[13] = mk(0, 2'b01, 2'b00, 49,  0,  0, 0, 2'b01, 2'b01, 9,  0);
      tbl[14] = mk(0, 2'b00, 2'b00,  0,  0,  0, 0, 2'b00, 2'b00, 9,  0);
      tbl[15] = mk(0, 2'b01, 2'b00,  1,  0,  0, 0, 2'b01, 2'b01, 3,  0);
      tbl[16] = mk(1, 2'b11, 2'b00,  1,  2,  0, 0, 2'b00, 2'b00, 0,  0);
      tbl[17] = mk(0, 2'b11, 2'b00,  1,  2,  0, 0, 2'b01, 2'b01, 0,  0);
      tbl[18] = mk(0, 2'b00, 2'b00,  0,  0,  0, 0, 2'b00, 2'b00, 0,  0);

      for (int i = 0; i < 19; i++) begin
         rst = tbl[i].rst; valid = tbl[i].v; wr = tbl[i].wr;
         addr = {tbl[i].a1, tbl[i].a0}; wdata = {tbl[i].d1, tbl[i].d0};
         step();
         chk($sformatf("vec%0d_ready", i),  32'(rdy_seen), 32'(tbl[i].e_rdy));
         chk($sformatf("vec%0d_rvalid", i), 32'(rvalid1),  32'(tbl[i].e_rvld));
         chk($sformatf("vec%0d_rdata", i),  32'(rdata1),   32'(tbl[i].e_rdata));
         chk($sformatf("vec%0d_err", i),    32'(err1),     32'(tbl[i].e_err));
         $display("vec %0d: ready=%b rvalid1=%b rdata1=%h err1=%b rvalid2=%b rdata2=%h",
                  i, rdy_seen, rvalid1, rdata1, err1, rvalid2, rdata2);
      end

      // Random traffic; a pending ungranted request is normally held stable.
      for (int n = 0; n < 1500; n++) begin
         for (int c = 0; c < NCH; c++) begin
            if (!(valid[c] && !rdy_seen[c]) || $urandom_range(0, 7) == 0) begin
               valid[c] = ($urandom_range(0, 2) != 0);
               wr[c]    = 1'($urandom);
               addr[c*AW +: AW] = AW'($urandom_range(0, 63));
               wdata[c*W +: W]  = W'($urandom);
            end
         end
         rst = ($urandom_range(0, 99) == 0);
         step();
         if (n % 100 == 0)
            $display("rand %0d: valid=%b wr=%b ready=%b rvalid1=%b rdata1=%h err1=%b",
                     n, valid, wr, rdy_seen, rvalid1, rdata1, err1);
      end

`ifdef MC_MEM_STATS_EN
      rst = 1'b1; valid = '0; step();
      rst = 1'b0; valid = 2'b01; wr = 2'b01; addr = '0; wdata = '0;
      for (int n = 0; n < 65540; n++) step();
      chk("wr_cnt_sat", 32'(wc1), 32'h0000FFFF);
      $display("sat: wr_cnt1=%h wr_cnt2=%h", wc1, wc2);
      valid = '0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
